// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel output stream stage.
package pixel_stream_pkg;

    localparam int PIXEL_W         = 8;
    localparam int PIX_CNT_SOBEL   = 3844;
    localparam int PIX_CNT_POOL_S1 = 3721;
    localparam int PIX_CNT_POOL_S2 = 961;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t;

endpackage

// File: rtl/pixel_serializer_if.sv
// Pixel input and serial output handshakes of the pixel serializer.
interface pixel_serializer_if
    import pixel_stream_pkg::*;
#(
    parameter int DATA_W = PIXEL_W
);
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              serial_data;
    logic              serial_valid;
    logic              serial_ready_in;

    modport master (
        output pix_data, pix_valid, serial_ready_in,
        input  pix_ready, serial_data, serial_valid
    );

    modport slave (
        input  pix_data, pix_valid, serial_ready_in,
        output pix_ready, serial_data, serial_valid
    );
endinterface

// File: rtl/pixel_piso.sv
// MSB-first parallel-in/serial-out shifter with bit counter and load port.
module pixel_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk_200mhz,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              serial_ready_in,
    output logic              serial_data,
    output logic              serial_valid,
    output logic              last_xfer
);
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic              sr_full;
    logic [BC_W-1:0]   bit_cnt;
    logic              xfer;

    assign xfer      = sr_full && serial_ready_in;
    assign last_xfer = xfer && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            sr      <= '0;
            sr_full <= 1'b0;
            bit_cnt <= '0;
        end else if (clr) begin
            sr      <= '0;
            sr_full <= 1'b0;
            bit_cnt <= '0;
        end else if (xfer) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                // Reloading on the last bit keeps back-to-back bytes gapless.
                if (load) begin
                    sr <= load_data;
                end else begin
                    sr      <= sr << 1;
                    sr_full <= 1'b0;
                end
            end else begin
                sr      <= sr << 1;
                bit_cnt <= bit_cnt + BC_W'(1);
            end
        end else if (load) begin
            sr      <= load_data;
            sr_full <= 1'b1;
        end
    end

    assign serial_data  = sr[DATA_W-1];
    assign serial_valid = sr_full;
endmodule

// File: rtl/pixel_serializer.sv
// Frame-counting pixel serializer: FIFO pixels in, one bit per transfer out.
module pixel_serializer
    import pixel_stream_pkg::*;
#(
    parameter int DATA_W    = PIXEL_W,
    parameter int PIXEL_CNT = PIX_CNT_POOL_S2,
    parameter int CNT_W     = $clog2(PIXEL_CNT + 1)
) (
    input  logic             clk_200mhz,
    input  logic             reset_n,
    input  logic             start,
    pixel_serializer_if.slave bus,
    output logic [CNT_W-1:0] pix_count,
    output logic             frame_done
);
    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic [CNT_W-1:0]  acc_cnt;
    logic              pix_ready_c;
    logic              clr;
    logic              accept;
    logic              load;
    logic              last_xfer;
    logic              frame_last;
    logic              sr_full;

    assign accept     = pix_ready_c && bus.pix_valid;
    assign load       = hold_full && (!sr_full || last_xfer);
    assign frame_last = last_xfer && (pix_count == CNT_W'(PIXEL_CNT - 1));

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A falling start in RUN is deliberately ignored so a frame always completes.
    always_comb begin
        state_d     = state_q;
        pix_ready_c = 1'b0;
        clr         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                pix_ready_c = !hold_full && (acc_cnt < CNT_W'(PIXEL_CNT));
                if (frame_last) state_d = DONE;
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            hold_full  <= 1'b0;
            acc_cnt    <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_last;
            if (clr) begin
                hold      <= '0;
                hold_full <= 1'b0;
                acc_cnt   <= '0;
                pix_count <= '0;
            end else begin
                if (accept) begin
                    hold      <= bus.pix_data;
                    hold_full <= 1'b1;
                    acc_cnt   <= acc_cnt + CNT_W'(1);
                end else if (load) begin
                    hold_full <= 1'b0;
                end
                if (last_xfer) pix_count <= pix_count + CNT_W'(1);
            end
        end
    end

    pixel_piso #(.DATA_W(DATA_W)) u_piso (
        .clk_200mhz      (clk_200mhz),
        .reset_n         (reset_n),
        .clr             (clr),
        .load            (load),
        .load_data       (hold),
        .serial_ready_in (bus.serial_ready_in),
        .serial_data     (bus.serial_data),
        .serial_valid    (sr_full),
        .last_xfer       (last_xfer)
    );

    assign bus.serial_valid = sr_full;
    assign bus.pix_ready    = pix_ready_c;
endmodule
